// File: rtl/case_2_mul_share_pkg.sv
// Shared constants, ID-width helper and default-configuration slot types for the
// round-robin shared-multiplier arbiter.
package case_2_mul_share_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_A_W     = 8;
  localparam int unsigned DEF_B_W     = 6;
  localparam int unsigned DEF_P_W     = DEF_A_W + DEF_B_W;

  // A single requester still needs a one-bit ID port.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_ID_W = id_width(DEF_NUM_REQ);

  typedef struct packed {
    logic                      valid;
    logic [DEF_ID_W-1:0]       id;
    logic signed [DEF_A_W-1:0] a;
    logic signed [DEF_B_W-1:0] b;
  } op_slot_t;

  typedef struct packed {
    logic                      valid;
    logic [DEF_ID_W-1:0]       id;
    logic signed [DEF_P_W-1:0] data;
  } prod_slot_t;

endpackage

// File: rtl/case_2_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The grant is gated by en, but the index is not.
module case_2_rr_picker
  import case_2_mul_share_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!found && req_valid[i] && (i == (int'(ptr) + k) % int'(NUM_REQ))) begin
          gnt[i] = en;
          idx    = ID_W'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/case_2_mul_share_arb.sv
// Round-robin arbiter sharing one signed A_W x B_W multiplier among NUM_REQ
// requesters through a MUL_STAGES-deep pipeline with global stall.
module case_2_mul_share_arb
  import case_2_mul_share_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter  int unsigned A_W        = DEF_A_W,
  parameter  int unsigned B_W        = DEF_B_W,
  parameter  int unsigned P_W        = DEF_P_W,
  parameter  int unsigned MUL_STAGES = 2,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  // Slot 0 holds operands when MUL_STAGES > 1; the remaining slots hold products.
  localparam int unsigned NPROD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  if (P_W != A_W + B_W) begin : g_bad_pw
    $error("P_W must equal A_W + B_W");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("MUL_STAGES must be in 1..4");
  end

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
  } op_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  data;
  } prod_t;

  logic               adv;
  logic               en;
  logic               fire;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  op_t                gnt_op;
  op_t                mul_src;
  logic               op_valid;
  logic [P_W-1:0]     product;
  prod_t              prod_in;
  prod_t              prod_q [NPROD];

  assign adv = !prod_q[NPROD-1].valid || rsp_ready;
  assign en  = adv && ap_rst_n;

  case_2_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .en        (en),
    .gnt       (gnt),
    .idx       (gnt_idx)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;

  always_comb begin
    gnt_op       = '0;
    gnt_op.valid = fire;
    gnt_op.id    = gnt_idx;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        gnt_op.a = req_a[i*A_W +: A_W];
        gnt_op.b = req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  if (MUL_STAGES > 1) begin : g_op_slot
    op_t op_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        op_q <= '0;
      end else if (adv) begin
        op_q <= gnt_op;
      end
    end

    assign mul_src  = op_q;
    assign op_valid = op_q.valid;
  end else begin : g_no_op_slot
    assign mul_src  = gnt_op;
    assign op_valid = 1'b0;
  end

  // Sign-extend both operands to P_W so the product is the exact signed result.
  assign product = $signed({{B_W{mul_src.a[A_W-1]}}, mul_src.a}) *
                   $signed({{A_W{mul_src.b[B_W-1]}}, mul_src.b});

  always_comb begin
    prod_in.valid = mul_src.valid;
    prod_in.id    = mul_src.id;
    prod_in.data  = product;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < int'(NPROD); i++) begin
        prod_q[i] <= '0;
      end
    end else if (adv) begin
      prod_q[0] <= prod_in;
      for (int i = 1; i < int'(NPROD); i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  always_comb begin
    busy = op_valid;
    for (int i = 0; i < int'(NPROD); i++) begin
      busy = busy | prod_q[i].valid;
    end
  end

  assign rsp_valid = prod_q[NPROD-1].valid;
  assign rsp_data  = prod_q[NPROD-1].data;
  assign rsp_id    = prod_q[NPROD-1].id;

endmodule

// File: tb/tb_case_2_mul_share_arb.sv
// Bench for case_2_mul_share_arb: directed vector table, hand-written arbitration,
// backpressure and reset sequences, and a scoreboard checking every response.
module tb_case_2_mul_share_arb;
  import case_2_mul_share_pkg::*;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned A_W        = 8;
  localparam int unsigned B_W        = 6;
  localparam int unsigned P_W        = 14;
  localparam int unsigned MUL_STAGES = 2;
  localparam int unsigned ID_W       = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [P_W-1:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  int n_cmp  = 0;
  int n_fail = 0;

  prod_slot_t exp_q[$];
  prod_slot_t mon_e;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [5:0] b;
    int         p;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  case_2_mul_share_arb #(
    .NUM_REQ    (NUM_REQ),
    .A_W        (A_W),
    .B_W        (B_W),
    .P_W        (P_W),
    .MUL_STAGES (MUL_STAGES)
  ) dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [5:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    @(posedge clk); #2;
    req_valid = '0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_busy_idle"}, int'(busy), 0);
    chk({name, "_rsp_valid_idle"}, int'(rsp_valid), 0);
  endtask

  // Scoreboard: retire on accepted responses, enqueue on accepted requests.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready_onehot0", int'($onehot0(req_ready)), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_rsp_id", int'(rsp_id), int'(mon_e.id));
          chk("sb_rsp_data", int'($signed(rsp_data)), int'(mon_e.data));
        end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{1'b1, 2'(i),
                            14'(int'($signed(req_a[i*A_W +: A_W])) *
                                int'($signed(req_b[i*B_W +: B_W])))});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, 8'h80, 6'h20, 4096};
    vecs[1] = '{0, 8'h7f, 6'h1f, 3937};
    vecs[2] = '{1, 8'h80, 6'h1f, -3968};
    vecs[3] = '{3, 8'h7f, 6'h20, -4064};
    vecs[4] = '{0, 8'h00, 6'h3f, 0};
    vecs[5] = '{2, 8'hff, 6'h3f, 1};
    vecs[6] = '{1, 8'h05, 6'h39, -35};
    vecs[7] = '{3, 8'h9c, 6'h14, -2000};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests pending to show req_ready is forced low.
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    @(posedge clk); #2;
    req_valid = '0;
    rst_n     = 1'b1;

    // Single transactions: grant, exact latency, product and tag.
    foreach (vecs[v]) begin
      @(posedge clk); #2;
      req_valid           = '0;
      req_valid[vecs[v].id] = 1'b1;
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("vec_req_ready", int'(req_ready), 1 << vecs[v].id);
      @(posedge clk); #2;
      req_valid = '0;
      for (int s = 1; s < int'(MUL_STAGES); s++) begin
        @(negedge clk);
        chk("vec_rsp_early", int'(rsp_valid), 0);
        @(posedge clk); #2;
      end
      @(negedge clk);
      chk("vec_rsp_valid", int'(rsp_valid), 1);
      chk("vec_rsp_data", int'($signed(rsp_data)), vecs[v].p);
      chk("vec_rsp_id", int'(rsp_id), vecs[v].id);
      chk("vec_busy", int'(busy), 1);
    end

    // Fairness: all valid from ptr=0, grants rotate 0,1,2,3,...
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < int'(NUM_REQ); i++) set_op(i, 8'(i + 1), 6'h3f);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", int'(req_ready), 1 << (k % 4));
      if (k >= 1) chk("rr_busy", int'(busy), 1);
      @(posedge clk); #2;
    end

    // Backpressure with a full pipeline: outputs frozen, no grants.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      if (exp_q.size() != 0) begin
        chk("bp_rsp_data", int'($signed(rsp_data)), int'(exp_q[0].data));
        chk("bp_rsp_id", int'(rsp_id), int'(exp_q[0].id));
      end
      @(posedge clk); #2;
    end
    drain("bp");

    // Requesters 1 and 3 with ptr moved to 2: 3 wins, then wrap to 1.
    @(posedge clk); #2;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("ptr_first", int'(req_ready), 4'b0010);
    @(posedge clk); #2;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("ptr_skip_to_3", int'(req_ready), 4'b1000);
    @(posedge clk); #2;
    @(negedge clk);
    chk("ptr_wrap_to_1", int'(req_ready), 4'b0010);
    drain("ptr");

    // Reset mid-stream with two transactions in flight.
    @(posedge clk); #2;
    req_valid = '1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    exp_q.delete();
    req_valid = 4'b1010;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", int'(req_ready), 4'b0010);
    drain("post_rst");

    // Random operands, request patterns and downstream stalls.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      req_valid = 4'($urandom);
      for (int i = 0; i < int'(NUM_REQ); i++) set_op(i, 8'($urandom), 6'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
